// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if
//   Bundles the two valid/ready handshakes of the pipelined logic unit.
//   The input side carries an op code and two operands. The output side
//   carries the result plus the Y86 condition codes.
//   Ports (all signals):
//     in_valid, in_ready, in_op[1:0], in_a[WIDTH-1:0], in_b[WIDTH-1:0]
//     out_valid, out_ready, out_result[WIDTH-1:0], out_zf, out_sf, out_of
//   Modports:
//     master - the producer/consumer around the unit (drives operands and out_ready)
//     slave  - the logic unit itself
interface logic_unit_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zf;
  logic             out_sf;
  logic             out_of;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zf, out_sf, out_of
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zf, out_sf, out_of
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Pipelined bitwise logic unit for the Y86-64 execute stage.
//   Supported ops are AND, OR, XOR and ANDN (a & ~b). The unit has
//   configurable width and depth. Each result travels with its ZF/SF/OF
//   condition codes.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - logic_unit_pipe_if.slave, which carries both handshakes:
//              in_valid/in_ready/in_op/in_a/in_b for the operands, and
//              out_valid/out_ready/out_result/out_zf/out_sf/out_of for the results
//   Parameters:
//     WIDTH  - operand/result width (>= 2)
//     DEPTH  - stages from accept to output (>= 1)
module logic_unit_pipe #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  logic_unit_pipe_if.slave     bus
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("logic_unit_pipe: DEPTH must be at least 1");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("logic_unit_pipe: WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  logic [WIDTH-1:0] res_c;
  logic             zf_c;
  logic             sf_c;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] zf_q;
  logic [DEPTH-1:0] sf_q;
  logic [WIDTH-1:0] res_q [DEPTH];

  logic [DEPTH-1:0] adv;
  logic             full_run;

  // Combinational result and flags for the operand set currently offered.
  always_comb begin
    res_c = '0;
    case (bus.in_op)
      OP_AND:  res_c = bus.in_a & bus.in_b;
      OP_OR:   res_c = bus.in_a | bus.in_b;
      OP_XOR:  res_c = bus.in_a ^ bus.in_b;
      OP_ANDN: res_c = bus.in_a & ~bus.in_b;
      default: res_c = '0;
    endcase
    zf_c = (res_c == '0);
    sf_c = res_c[WIDTH-1];
  end

  // Stage k may advance unless it and every stage downstream of it are full
  // while the consumer stalls. The chain adv[k] = !v[k] | adv[k+1] is
  // evaluated as "not all of v[DEPTH-1:k] full, or out_ready". This avoids
  // a bit-level feedback loop inside the adv vector.
  always_comb begin
    adv      = '0;
    full_run = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      full_run = full_run & v_q[k];
      adv[k]   = !full_run | bus.out_ready;
    end
  end

  // Stage 0 takes a new entry on an input transfer. Every later stage takes
  // the entry from the stage before it whenever it advances. A stage that
  // advances with nothing arriving becomes a bubble. Its data is left
  // untouched so that only valid bits toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      zf_q <= '0;
      sf_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          res_q[0] <= res_c;
          zf_q[0]  <= zf_c;
          sf_q[0]  <= sf_c;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            res_q[k] <= res_q[k-1];
            zf_q[k]  <= zf_q[k-1];
            sf_q[k]  <= sf_q[k-1];
          end
        end
      end
    end
  end

  // in_ready is gated by rst_n. An empty pipe would otherwise advertise
  // space while it is still held in reset.
  assign bus.in_ready   = adv[0] & rst_n;
  assign bus.out_valid  = v_q[DEPTH-1];
  assign bus.out_result = res_q[DEPTH-1];
  assign bus.out_zf     = zf_q[DEPTH-1];
  assign bus.out_sf     = sf_q[DEPTH-1];
  // Bitwise ops can never overflow, so OF is constant zero.
  assign bus.out_of     = 1'b0;

endmodule
